// File: rtl/flash_packet_rx.sv
// Flash image packet receiver: parses UDP payload headers and streams
// program-packet data into the flash Rx FIFO, one page per packet.
module flash_packet_rx #(
   parameter int BLOCK_BYTES = 256,
   parameter int FIFO_LIMIT  = 767
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_sop,
   input  logic [9:0]  fifo_wrused,
   output logic        fifo_wrreq,
   output logic [7:0]  fifo_data,
   output logic        erase,
   input  logic        erase_ACK,
   output logic [13:0] num_blocks,
   output logic        prog_active,
   output logic [13:0] blocks_rx,
   output logic        pkt_error
);

   localparam int CW = $clog2(BLOCK_BYTES + 1);
   localparam logic [CW-1:0] LAST = CW'(BLOCK_BYTES - 1);
   localparam logic [9:0] LIMIT = FIFO_LIMIT[9:0];

   typedef enum logic [2:0] {
      IDLE, HDR, CNT, CHECK, DATA, ERASE_WAIT, DISCARD
   } state_t;

   state_t state, nxt;

   logic [1:0]    idx;
   logic [31:0]   cnt;
   logic [CW-1:0] dcnt;

   logic sop, start;
   logic do_wr, do_erase, do_latch, do_err, do_blk, ack_done;

   assign sop   = rx_valid & rx_sop;
   assign start = sop & (rx_data == 8'hEF);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   always_comb begin
      nxt      = state;
      do_wr    = 1'b0;
      do_erase = 1'b0;
      do_latch = 1'b0;
      do_err   = 1'b0;
      do_blk   = 1'b0;
      ack_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) nxt = HDR;
         end
         HDR: begin
            if (sop) begin
               nxt = start ? HDR : IDLE;
            end else if (rx_valid) begin
               unique case (idx)
                  2'd1: if (rx_data != 8'hFE) nxt = DISCARD;
                  2'd2: if (rx_data != 8'h03) nxt = DISCARD;
                  2'd3: begin
                     if (rx_data == 8'h01) begin
                        nxt = CNT;
                     end else if (rx_data == 8'h02) begin
                        nxt      = ERASE_WAIT;
                        do_erase = 1'b1;
                     end else begin
                        nxt = DISCARD;
                     end
                  end
                  default: nxt = DISCARD;
               endcase
            end
         end
         CNT: begin
            if (sop) nxt = start ? HDR : IDLE;
            else if (rx_valid && idx == 2'd3) nxt = CHECK;
         end
         CHECK: begin
            // A fresh image validates and adopts its own count here
            if (sop) begin
               nxt = start ? HDR : IDLE;
            end else if (!prog_active && (cnt == 32'd0 || cnt > 32'd16383)) begin
               do_err = 1'b1;
               nxt    = DISCARD;
            end else if (prog_active && cnt != {18'd0, num_blocks}) begin
               do_err = 1'b1;
               nxt    = DISCARD;
            end else begin
               do_latch = !prog_active;
               if (blocks_rx == cnt[13:0]) begin
                  nxt = DISCARD;
               end else if (fifo_wrused > LIMIT) begin
                  do_err = 1'b1;
                  nxt    = DISCARD;
               end else begin
                  nxt = DATA;
               end
            end
         end
         DATA: begin
            if (sop) begin
               do_err = 1'b1;
               nxt    = start ? HDR : IDLE;
            end else if (rx_valid) begin
               do_wr = 1'b1;
               if (dcnt == LAST) begin
                  do_blk = 1'b1;
                  nxt    = DISCARD;
               end
            end
         end
         ERASE_WAIT: begin
            if (erase_ACK) begin
               ack_done = 1'b1;
               nxt      = DISCARD;
            end
         end
         DISCARD: begin
            if (sop) nxt = start ? HDR : IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idx  <= 2'd0;
         cnt  <= 32'd0;
         dcnt <= '0;
      end else begin
         if (sop) idx <= 2'd1;
         else if (rx_valid) idx <= idx + 2'd1;
         if (state == CNT && rx_valid && !rx_sop)
            cnt <= {cnt[23:0], rx_data};
         if (state != DATA) dcnt <= '0;
         else if (do_wr) dcnt <= dcnt + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fifo_wrreq  <= 1'b0;
         fifo_data   <= 8'd0;
         erase       <= 1'b0;
         num_blocks  <= 14'd0;
         prog_active <= 1'b0;
         blocks_rx   <= 14'd0;
         pkt_error   <= 1'b0;
      end else begin
         fifo_wrreq <= do_wr;
         if (do_wr) fifo_data <= rx_data;
         if (do_erase) begin
            erase       <= 1'b1;
            prog_active <= 1'b0;
            blocks_rx   <= 14'd0;
            pkt_error   <= 1'b0;
         end else if (ack_done) begin
            erase <= 1'b0;
         end
         if (do_err) pkt_error <= 1'b1;
         if (do_latch) begin
            num_blocks  <= cnt[13:0];
            prog_active <= (blocks_rx != cnt[13:0]);
         end
         if (do_blk && blocks_rx != num_blocks) begin
            blocks_rx <= blocks_rx + 14'd1;
            if (blocks_rx + 14'd1 == num_blocks) prog_active <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_flash_packet_rx.sv
// Scoreboard bench for flash_packet_rx: expected FIFO bytes are queued as
// data is driven and matched against fifo_wrreq/fifo_data.
module tb_flash_packet_rx;

   logic        clock;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sop;
   logic [9:0]  fifo_wrused;
   logic        fifo_wrreq;
   logic [7:0]  fifo_data;
   logic        erase;
   logic        erase_ACK;
   logic [13:0] num_blocks;
   logic        prog_active;
   logic [13:0] blocks_rx;
   logic        pkt_error;

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] exp_q[$];

   flash_packet_rx dut (
      .clock(clock), .reset_n(reset_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
      .fifo_wrused(fifo_wrused),
      .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
      .erase(erase), .erase_ACK(erase_ACK),
      .num_blocks(num_blocks), .prog_active(prog_active),
      .blocks_rx(blocks_rx), .pkt_error(pkt_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge clock) begin
      if (reset_n && fifo_wrreq) begin
         if (exp_q.size() == 0) check("wr_extra", 32'(fifo_wrreq), 32'd0);
         else check("wr_data", 32'(fifo_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input bit sop, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      rx_sop   = sop;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
      rx_sop   = 1'b0;
      rx_data  = 8'h00;
      idle(gap);
   endtask

   task automatic send_hdr(input logic [7:0] cmd);
      send(8'hEF, 1'b1, 0);
      send(8'hFE, 1'b0, 0);
      send(8'h03, 1'b0, 0);
      send(cmd, 1'b0, 0);
   endtask

   task automatic send_prog(input logic [31:0] count, input int nbytes,
                            input int gap, input bit wr);
      send_hdr(8'h01);
      for (int i = 3; i >= 0; i--) send(count[i*8 +: 8], 1'b0, 0);
      idle(1);
      for (int i = 0; i < nbytes; i++) begin
         if (wr) exp_q.push_back(8'(i));
         send(8'(i), 1'b0, gap);
      end
      idle(3);
      check("q_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_erase(input bit busy_byte);
      send_hdr(8'h02);
      check("erase_set", 32'(erase), 32'd1);
      check("erase_clr_err", 32'(pkt_error), 32'd0);
      check("erase_clr_blk", 32'(blocks_rx), 32'd0);
      if (busy_byte) send(8'hEF, 1'b1, 0);
      idle(3);
      check("erase_hold", 32'(erase), 32'd1);
      erase_ACK = 1'b1;
      @(posedge clock);
      #1;
      erase_ACK = 1'b0;
      check("erase_drop", 32'(erase), 32'd0);
      idle(2);
   endtask

   initial begin
      reset_n     = 1'b0;
      rx_data     = 8'h00;
      rx_valid    = 1'b0;
      rx_sop      = 1'b0;
      fifo_wrused = 10'd0;
      erase_ACK   = 1'b0;
      idle(3);
      check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
      check("rst_data", 32'(fifo_data), 32'd0);
      check("rst_erase", 32'(erase), 32'd0);
      check("rst_nblk", 32'(num_blocks), 32'd0);
      check("rst_blk", 32'(blocks_rx), 32'd0);
      check("rst_err", 32'(pkt_error | prog_active), 32'd0);
      reset_n = 1'b1;
      idle(2);

      do_erase(1'b1);

      send_prog(32'd2, 256, 0, 1'b1);
      check("p1_blk", 32'(blocks_rx), 32'd1);
      check("p1_nblk", 32'(num_blocks), 32'd2);
      check("p1_active", 32'(prog_active), 32'd1);

      send_prog(32'd3, 256, 0, 1'b0);
      check("mm_err", 32'(pkt_error), 32'd1);
      check("mm_blk", 32'(blocks_rx), 32'd1);

      do_erase(1'b0);
      fifo_wrused = 10'd768;
      send_prog(32'd2, 256, 0, 1'b0);
      check("bp_err", 32'(pkt_error), 32'd1);
      check("bp_blk", 32'(blocks_rx), 32'd0);

      do_erase(1'b0);
      fifo_wrused = 10'd767;
      send_prog(32'd2, 256, 0, 1'b1);
      check("lim_err", 32'(pkt_error), 32'd0);
      check("lim_blk", 32'(blocks_rx), 32'd1);
      fifo_wrused = 10'd0;
      send_prog(32'd2, 256, 0, 1'b1);
      check("p2_blk", 32'(blocks_rx), 32'd2);
      check("p2_active", 32'(prog_active), 32'd0);
      check("p2_nblk", 32'(num_blocks), 32'd2);
      send_prog(32'd2, 256, 0, 1'b0);
      check("p3_blk", 32'(blocks_rx), 32'd2);
      check("p3_err", 32'(pkt_error), 32'd0);

      do_erase(1'b0);
      send_prog(32'd2, 100, 0, 1'b1);
      check("ab_blk0", 32'(blocks_rx), 32'd0);
      check("ab_err0", 32'(pkt_error), 32'd0);
      send_prog(32'd2, 256, 2, 1'b1);
      check("ab_err", 32'(pkt_error), 32'd1);
      check("ab_blk", 32'(blocks_rx), 32'd1);

      send_prog(32'd2, 50, 1, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mr_blk", 32'(blocks_rx), 32'd0);
      check("mr_err", 32'(pkt_error | prog_active | erase), 32'd0);
      check("mr_nblk", 32'(num_blocks), 32'd0);
      check("mr_wr", 32'(fifo_wrreq), 32'd0);
      idle(2);
      reset_n = 1'b1;
      idle(1);
      send_prog(32'd1, 256, 0, 1'b1);
      check("post_blk", 32'(blocks_rx), 32'd1);
      check("post_active", 32'(prog_active), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
